// File: rtl/race_controller_pkg.sv
// Shared types and track geometry for the kart race sequencer.
package race_pkg;

  typedef enum logic [2:0] {
    GS_IDLE      = 3'd0,
    GS_WON       = 3'd1,
    GS_LOST      = 3'd2,
    GS_COUNTDOWN = 3'd3,
    GS_RACING    = 3'd4
  } game_stat_t;

  localparam int NUM_CP = 4;
  localparam int POS_W  = 11;

  // Checkpoint rectangles, inclusive bounds; cp0 doubles as the start/finish line.
  localparam logic [POS_W-1:0] CP_X_LO [NUM_CP] = '{11'd100, 11'd800, 11'd800, 11'd100};
  localparam logic [POS_W-1:0] CP_X_HI [NUM_CP] = '{11'd199, 11'd899, 11'd899, 11'd199};
  localparam logic [POS_W-1:0] CP_Y_LO [NUM_CP] = '{11'd100, 11'd100, 11'd800, 11'd800};
  localparam logic [POS_W-1:0] CP_Y_HI [NUM_CP] = '{11'd199, 11'd199, 11'd899, 11'd899};

  function automatic logic in_rect(input logic [POS_W-1:0] x,
                                   input logic [POS_W-1:0] y,
                                   input logic [1:0]       idx);
    return (x >= CP_X_LO[idx]) && (x <= CP_X_HI[idx]) &&
           (y >= CP_Y_LO[idx]) && (y <= CP_Y_HI[idx]);
  endfunction

endpackage

// File: rtl/race_controller_if.sv
// Frame-level signals between the input/network layer and the race sequencer.
interface race_controller_if;
  logic        frame_tick;
  logic        start_btn;
  logic        opp_ready;
  logic [2:0]  opp_game;
  logic        opp_rst;
  logic [10:0] player_x;
  logic [10:0] player_y;
  logic [2:0]  game_stat;
  logic        move_en;
  logic [2:0]  laps;
  logic [1:0]  count_val;
  logic [1:0]  next_cp;

  modport master (
    output frame_tick, start_btn, opp_ready, opp_game, opp_rst, player_x, player_y,
    input  game_stat, move_en, laps, count_val, next_cp
  );

  modport slave (
    input  frame_tick, start_btn, opp_ready, opp_game, opp_rst, player_x, player_y,
    output game_stat, move_en, laps, count_val, next_cp
  );
endinterface

// File: rtl/race_controller_checkpoint_tracker.sv
// Ordered checkpoint sequencer: only the expected checkpoint advances, so
// wrong-way driving and shortcuts never complete a lap.
module checkpoint_tracker
  import race_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             clr,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  output logic [1:0]       next_cp,
  output logic             lap_done
);

  logic [1:0] next_cp_q, next_cp_d;
  logic       passed_q, passed_d;
  logic       hit;
  logic       adv;

  always_comb begin
    hit       = in_rect(pos_x, pos_y, next_cp_q);
    adv       = tick & en & hit & ~clr;
    // passed_q marks that cp1..cp3 were taken in order since the last cp0
    lap_done  = adv & (next_cp_q == 2'd0) & passed_q;
    next_cp_d = next_cp_q;
    passed_d  = passed_q;
    if (clr) begin
      next_cp_d = 2'd0;
      passed_d  = 1'b0;
    end else if (adv) begin
      next_cp_d = next_cp_q + 2'd1;
      passed_d  = (next_cp_q == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_cp_q <= 2'd0;
      passed_q  <= 1'b0;
    end else begin
      next_cp_q <= next_cp_d;
      passed_q  <= passed_d;
    end
  end

  assign next_cp = next_cp_q;

endmodule

// File: rtl/race_controller.sv
// Frame-synchronous race sequencer: start handshake, countdown, laps, win/lose.
// Define RACE_COUNTDOWN_EN to include the start countdown; otherwise IDLE goes straight to RACING.
module race_controller
  import race_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNT_SECS     = 3,
  parameter int LAPS_TO_WIN    = 3
) (
  input  logic              clk,
  input  logic              rst,
  race_controller_if.slave  bus
);

  localparam logic [2:0] LAPS_MAX = 3'(LAPS_TO_WIN);

  game_stat_t state_q, state_d;
  logic       move_en_q, move_en_d;
  logic [2:0] laps_q, laps_d;
  logic [1:0] next_cp;
  logic       lap_done;
  logic       racing;

`ifdef RACE_COUNTDOWN_EN
  localparam int               FC_W    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAMES_PER_SEC - 1);
  localparam logic [1:0]       SECS    = 2'(COUNT_SECS);

  logic [1:0]      count_q, count_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
`endif

  assign racing = (state_q == GS_RACING);

  checkpoint_tracker u_cp (
    .clk      (clk),
    .rst      (rst),
    .tick     (bus.frame_tick),
    .en       (racing),
    .clr      (bus.opp_rst),
    .pos_x    (bus.player_x),
    .pos_y    (bus.player_y),
    .next_cp  (next_cp),
    .lap_done (lap_done)
  );

  always_comb begin
    state_d = state_q;
    laps_d  = laps_q;
`ifdef RACE_COUNTDOWN_EN
    count_d = count_q;
    fcnt_d  = fcnt_q;
`endif
    if (bus.opp_rst) begin
      state_d = GS_IDLE;
      laps_d  = 3'd0;
`ifdef RACE_COUNTDOWN_EN
      count_d = 2'd0;
      fcnt_d  = '0;
`endif
    end else if (bus.frame_tick) begin
      case (state_q)
        GS_IDLE: begin
          if (bus.start_btn && bus.opp_ready) begin
`ifdef RACE_COUNTDOWN_EN
            state_d = GS_COUNTDOWN;
            count_d = SECS;
            fcnt_d  = '0;
`else
            state_d = GS_RACING;
`endif
          end
        end
`ifdef RACE_COUNTDOWN_EN
        GS_COUNTDOWN: begin
          if (fcnt_q == FC_LAST) begin
            fcnt_d = '0;
            if (count_q == 2'd1) begin
              state_d = GS_RACING;
              count_d = 2'd0;
            end else begin
              count_d = count_q - 2'd1;
            end
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
`endif
        GS_RACING: begin
          if (lap_done) begin
            laps_d = laps_q + 3'd1;
          end
          // Finishing the final lap beats a simultaneous opponent win
          if (lap_done && ((laps_q + 3'd1) == LAPS_MAX)) begin
            state_d = GS_WON;
          end else if (bus.opp_game == 3'd1) begin
            state_d = GS_LOST;
          end
        end
        default: ;
      endcase
    end
    move_en_d = (state_d == GS_RACING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GS_IDLE;
      move_en_q <= 1'b0;
      laps_q    <= 3'd0;
`ifdef RACE_COUNTDOWN_EN
      count_q   <= 2'd0;
      fcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      move_en_q <= move_en_d;
      laps_q    <= laps_d;
`ifdef RACE_COUNTDOWN_EN
      count_q   <= count_d;
      fcnt_q    <= fcnt_d;
`endif
    end
  end

  assign bus.game_stat = state_q;
  assign bus.move_en   = move_en_q;
  assign bus.laps      = laps_q;
  assign bus.next_cp   = next_cp;
`ifdef RACE_COUNTDOWN_EN
  assign bus.count_val = count_q;
`else
  assign bus.count_val = 2'd0;
`endif

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller: directed race scenarios plus randomized play against a behavioural model.
module tb_race_controller;

  localparam int FPS  = 60;
  localparam int SECS = 3;
  localparam int LAPS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  race_controller_if bus();

  race_controller #(
    .FRAMES_PER_SEC (FPS),
    .COUNT_SECS     (SECS),
    .LAPS_TO_WIN    (LAPS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Track geometry as the game designers laid it out
  int rx_lo [4] = '{100, 800, 800, 100};
  int rx_hi [4] = '{199, 899, 899, 199};
  int ry_lo [4] = '{100, 100, 800, 800};
  int ry_hi [4] = '{199, 199, 899, 899};

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: stat code, total in-order checkpoint hits, seconds left, ticks into current second
  int m_stat = 0;
  int m_hits = 0;
  int m_secs = 0;
  int m_frames = 0;

  function automatic int which_cp(input int x, input int y);
    for (int i = 0; i < 4; i++)
      if (x >= rx_lo[i] && x <= rx_hi[i] && y >= ry_lo[i] && y <= ry_hi[i]) return i;
    return -1;
  endfunction

  // The first cp0 crossing only opens the race; each later group of four completes a lap
  function automatic int m_laps();
    return (m_hits == 0) ? 0 : (m_hits - 1) / 4;
  endfunction

  task automatic chk(input string nm, input integer act, input integer exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    int c;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_stat = 0; m_hits = 0; m_secs = 0; m_frames = 0;
      end else if (bus.opp_rst) begin
        m_stat = 0; m_hits = 0; m_secs = 0; m_frames = 0;
      end else if (bus.frame_tick) begin
        case (m_stat)
          0: if (bus.start_btn && bus.opp_ready) begin
`ifdef RACE_COUNTDOWN_EN
               m_stat = 3; m_secs = SECS; m_frames = 0;
`else
               m_stat = 4;
`endif
             end
          3: begin
               m_frames++;
               if (m_frames == FPS) begin
                 m_frames = 0;
                 m_secs--;
                 if (m_secs == 0) m_stat = 4;
               end
             end
          4: begin
               c = which_cp(int'(bus.player_x), int'(bus.player_y));
               if (c == m_hits % 4) m_hits++;
               if (m_laps() == LAPS) m_stat = 1;
               else if (bus.opp_game == 3'd1) m_stat = 2;
             end
          default: ;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("game_stat", bus.game_stat, m_stat);
        chk("move_en",   bus.move_en,   (m_stat == 4) ? 1 : 0);
        chk("laps",      bus.laps,      m_laps());
        chk("next_cp",   bus.next_cp,   m_hits % 4);
        chk("count_val", bus.count_val, m_secs);
      end
    end
  end

  task automatic step(input logic tk, input logic sb, input logic rdy, input logic orst,
                      input logic [2:0] og, input int x, input int y);
    bus.frame_tick = tk;
    bus.start_btn  = sb;
    bus.opp_ready  = rdy;
    bus.opp_rst    = orst;
    bus.opp_game   = og;
    bus.player_x   = 11'(x);
    bus.player_y   = 11'(y);
    @(negedge clk);
    #1;
  endtask

  task automatic tick_cp(input int i, input logic [2:0] og);
    step(1'b1, 1'b0, 1'b0, 1'b0, og, (rx_lo[i] + rx_hi[i]) / 2, (ry_lo[i] + ry_hi[i]) / 2);
  endtask

  task automatic start_race();
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 0, 0);
`ifdef RACE_COUNTDOWN_EN
    repeat (FPS * SECS) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
`endif
  endtask

  task automatic do_opp_rst();
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
  endtask

  initial begin
    int r, k, x, y;
    logic [2:0] og;
    bus.frame_tick = 1'b0; bus.start_btn = 1'b0; bus.opp_ready = 1'b0; bus.opp_rst = 1'b0;
    bus.opp_game = 3'd0; bus.player_x = '0; bus.player_y = '0;
    @(negedge clk); #1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
    chk_en = 1'b1;
    chk("rst game_stat", bus.game_stat, 0);
    chk("rst move_en", bus.move_en, 0);
    chk("rst laps", bus.laps, 0);
    chk("rst next_cp", bus.next_cp, 0);
    chk("rst count_val", bus.count_val, 0);

    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 0, 0);
    chk("no opp_ready stays idle", bus.game_stat, 0);

    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 0, 0);
`ifdef RACE_COUNTDOWN_EN
    chk("start game_stat", bus.game_stat, 3);
    chk("start count_val", bus.count_val, 3);
    chk("start move_en", bus.move_en, 0);
    repeat (FPS * SECS - 1) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
    chk("last second stat", bus.game_stat, 3);
    chk("last second count", bus.count_val, 1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
    chk("no tick holds count", bus.count_val, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
    chk("countdown done count", bus.count_val, 0);
`endif
    chk("racing game_stat", bus.game_stat, 4);
    chk("racing move_en", bus.move_en, 1);

    tick_cp(0, 3'd0);
    chk("cp0 open next_cp", bus.next_cp, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 900, 150);
    chk("outside cp1 edge", bus.next_cp, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 899, 199);
    chk("cp1 corner inclusive", bus.next_cp, 2);
    tick_cp(2, 3'd0);
    chk("cp2 next_cp", bus.next_cp, 3);
    tick_cp(3, 3'd0);
    chk("cp3 next_cp", bus.next_cp, 0);
    chk("cp3 laps", bus.laps, 0);
    tick_cp(0, 3'd0);
    chk("lap1 next_cp", bus.next_cp, 1);
    chk("lap1 laps", bus.laps, 1);
    for (int l = 0; l < 4; l++) tick_cp((l + 1) % 4, 3'd0);
    chk("lap2 laps", bus.laps, 2);
    chk("lap2 stat", bus.game_stat, 4);
    for (int l = 0; l < 4; l++) tick_cp((l + 1) % 4, 3'd0);
    chk("win stat", bus.game_stat, 1);
    chk("win move_en", bus.move_en, 0);
    chk("win laps", bus.laps, 3);
    tick_cp(1, 3'd0);
    chk("won holds laps", bus.laps, 3);
    chk("won holds stat", bus.game_stat, 1);

    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0);
    chk("opp_rst stat", bus.game_stat, 0);
    chk("opp_rst laps", bus.laps, 0);
    chk("opp_rst next_cp", bus.next_cp, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);

    start_race();
    tick_cp(0, 3'd0);
    tick_cp(3, 3'd0);
    tick_cp(0, 3'd0);
    chk("wrong way laps", bus.laps, 0);
    chk("wrong way next_cp", bus.next_cp, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 0, 0);
    chk("lost stat", bus.game_stat, 2);
    chk("lost move_en", bus.move_en, 0);
    tick_cp(1, 3'd0);
    tick_cp(2, 3'd0);
    chk("lost holds laps", bus.laps, 0);
    chk("lost holds next_cp", bus.next_cp, 1);

    do_opp_rst();
    start_race();
    tick_cp(0, 3'd0);
    for (int l = 0; l < 8; l++) tick_cp((l + 1) % 4, 3'd0);
    tick_cp(1, 3'd0);
    tick_cp(2, 3'd0);
    tick_cp(3, 3'd0);
    tick_cp(0, 3'd1);
    chk("win beats loss", bus.game_stat, 1);

    do_opp_rst();
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 0, 0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
    tick_cp(0, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst stat", bus.game_stat, 0);
    chk("async rst move_en", bus.move_en, 0);
    chk("async rst laps", bus.laps, 0);
    chk("async rst next_cp", bus.next_cp, 0);
    chk("async rst count", bus.count_val, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 0, 0);
    chk("post rst idle", bus.game_stat, 0);

    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 49));
      og = (r == 0) ? 3'd1 : ((r < 25) ? 3'd0 : ((r < 37) ? 3'd3 : 3'd4));
      k = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 7));
      if (r < 4) begin
        k = m_hits % 4;
        x = (rx_lo[k] + rx_hi[k]) / 2; y = (ry_lo[k] + ry_hi[k]) / 2;
      end else if (r == 4) begin
        x = $urandom_range(0, 1) ? rx_hi[k] : rx_lo[k];
        y = $urandom_range(0, 1) ? ry_hi[k] : ry_lo[k];
      end else if (r == 5) begin
        x = rx_lo[k] - 1; y = ry_lo[k];
      end else if (r == 6) begin
        x = int'($urandom_range(0, 2047)); y = int'($urandom_range(0, 2047));
      end else begin
        x = (rx_lo[k] + rx_hi[k]) / 2; y = (ry_lo[k] + ry_hi[k]) / 2;
      end
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) == 0, og, x, y);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
